// File: rtl/lattice_result_collector.sv
// Lattice result collector: gathers winning nonces from the last lattice stage
// into a small first-word-fall-through FIFO and keeps per-job statistics
// (rounds completed, dropped results, overflow and nonce-space exhaustion).
module lattice_result_collector #(
  parameter int LOG2_NUM_CORES = 1,
  parameter int NONCE_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   job_start,
  input  logic                                   in_valid,
  input  logic                                   in_success,
  input  logic [LOG2_NUM_CORES-1:0]              in_prefix,
  input  logic [NONCE_WIDTH-LOG2_NUM_CORES-1:0]  in_round,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NONCE_WIDTH-1:0]                 out_nonce,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_count,
  output logic [31:0]                            rounds_done,
  output logic [7:0]                             drop_count,
  output logic                                   overflow,
  output logic                                   exhausted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [NONCE_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [31:0]   rounds_q, rounds_d;
  logic [7:0]    drops_q,  drops_d;
  logic          ovf_q,    ovf_d;
  logic          exh_q,    exh_d;

  logic push_req, pop, full, push_ok, drop;

  // A new job wins over everything else arriving in the same cycle.
  assign push_req = in_valid && in_success && !job_start;
  assign pop      = out_valid && out_ready && !job_start;
  // Fullness comes from the count; equal pointers alone cannot tell full from empty.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign out_valid   = (count_q != '0);
  // Empty (and therefore in reset) reads as zero instead of stale storage.
  assign out_nonce   = out_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign rounds_done = rounds_q;
  assign drop_count  = drops_q;
  assign overflow    = ovf_q;
  assign exhausted   = exh_q;

  // Next-state for pointers, occupancy and job statistics.
  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rounds_d = rounds_q;
    drops_d  = drops_q;
    ovf_d    = ovf_q;
    exh_d    = exh_q;
    if (job_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rounds_d = '0;
      drops_d  = '0;
      ovf_d    = 1'b0;
      exh_d    = 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
      end
      if (in_valid) begin
        if (rounds_q != '1) rounds_d = rounds_q + 32'd1;
        if (&in_round)      exh_d    = 1'b1;
      end
    end
  end

  // Control and statistics registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rounds_q <= '0;
      drops_q  <= '0;
      ovf_q    <= 1'b0;
      exh_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rounds_q <= rounds_d;
      drops_q  <= drops_d;
      ovf_q    <= ovf_d;
      exh_q    <= exh_d;
    end
  end

  // Result storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; a zero count already hides any stale entries.
    if (push_ok) mem[wr_ptr_q] <= {in_round, in_prefix};
  end

endmodule

// File: tb/tb_lattice_result_collector.sv
// Self-checking bench for lattice_result_collector (LOG2=1, NONCE_WIDTH=32, FIFO_DEPTH=4).
// A queue scoreboard tracks expected FIFO contents and job statistics; a vector
// table covers the basic cases, hand-written sequences cover the multi-cycle ones.
module tb_lattice_result_collector;

  localparam int LOG2  = 1;
  localparam int NW    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_start, in_valid, in_success, out_ready;
  logic [0:0]  in_prefix;
  logic [30:0] in_round;
  logic        out_valid;
  logic [31:0] out_nonce;
  logic [2:0]  fifo_count;
  logic [31:0] rounds_done;
  logic [7:0]  drop_count;
  logic        overflow, exhausted;

  lattice_result_collector #(
    .LOG2_NUM_CORES(LOG2),
    .NONCE_WIDTH   (NW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_start  (job_start),
    .in_valid   (in_valid),
    .in_success (in_success),
    .in_prefix  (in_prefix),
    .in_round   (in_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nonce  (out_nonce),
    .fifo_count (fifo_count),
    .rounds_done(rounds_done),
    .drop_count (drop_count),
    .overflow   (overflow),
    .exhausted  (exhausted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected FIFO contents plus reference statistics.
  logic [31:0] sb[$];
  longint      m_rounds;
  int          m_drops;
  logic        m_ovf, m_exh;

  typedef struct {
    logic        js, iv, is;
    logic [0:0]  pf;
    logic [30:0] rd;
    logic        orr;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_nonce;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_rounds = 0;
    m_drops  = 0;
    m_ovf    = 1'b0;
    m_exh    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] head;
    head = (sb.size() != 0) ? sb[0] : 32'h0;
    check({tag, ".fifo_count"},  fifo_count,  sb.size());
    check({tag, ".out_valid"},   out_valid,   sb.size() != 0);
    check({tag, ".out_nonce"},   out_nonce,   head);
    check({tag, ".rounds_done"}, rounds_done, m_rounds);
    check({tag, ".drop_count"},  drop_count,  m_drops);
    check({tag, ".overflow"},    overflow,    m_ovf);
    check({tag, ".exhausted"},   exhausted,   m_exh);
  endtask

  // Called at posedge+1: drive inputs, update the model, clock, compare.
  task automatic step(input logic js, input logic iv, input logic is,
                      input logic [0:0] pf, input logic [30:0] rd, input logic orr);
    logic [31:0] popped;
    job_start  = js;
    in_valid   = iv;
    in_success = is;
    in_prefix  = pf;
    in_round   = rd;
    out_ready  = orr;
    if (js) begin
      model_reset();
    end else begin
      if (sb.size() != 0 && orr) begin
        popped = sb.pop_front();
        check("pop_nonce", out_nonce, popped);
      end
      if (iv && is) begin
        if (sb.size() < DEPTH) sb.push_back({rd, pf});
        else begin
          m_ovf = 1'b1;
          if (m_drops != 255) m_drops++;
        end
      end
      if (iv) begin
        if (m_rounds != 64'hFFFF_FFFF) m_rounds++;
        if (&rd) m_exh = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  task automatic idle();
    job_start = 0; in_valid = 0; in_success = 0;
    in_prefix = '0; in_round = '0; out_ready = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 31'h0,    1'b0, 3'd0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 31'h1234, 1'b0, 3'd1, 32'h0000_2469};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 31'h5,    1'b0, 3'd1, 32'h0000_2469};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 31'h7,    1'b0, 3'd1, 32'h0000_2469};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 31'h2,    1'b1, 3'd1, 32'h0000_0004};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 31'h0,    1'b1, 3'd0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 31'h0,    1'b1, 3'd0, 32'h0};

    // Power-on reset.
    rst = 1'b1;
    idle();
    model_reset();
    #7;
    check_state("reset");
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven basic vectors: push, latency, ignored success, push+pop, pop-on-empty.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].js, vecs[i].iv, vecs[i].is, vecs[i].pf, vecs[i].rd, vecs[i].orr);
      check($sformatf("vec%0d.count", i), fifo_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d.nonce", i), out_nonce,  vecs[i].exp_nonce);
    end
    check("vec.rounds", rounds_done, 32'd3);

    // Overflow: five pushes with the consumer stalled, then drain in order.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 31'h10 + 31'(i), 0);
    check("ovf.count", fifo_count, 3'd4);
    check("ovf.flag",  overflow,   1'b1);
    check("ovf.drops", drop_count, 8'd1);
    step(0, 0, 0, 0, 0, 0);
    check("ovf.hold",  out_nonce,  32'h20);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf.order%0d", i), out_nonce, 32'h20 + 32'(2 * i));
      step(0, 0, 0, 0, 0, 1);
    end
    check("ovf.empty", out_valid, 1'b0);

    // Full FIFO, push and pop on the same edge.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 31'h30 + 31'(i), 0);
    step(0, 1, 1, 1, 31'h55, 1);
    check("full_pp.count", fifo_count, 3'd4);
    check("full_pp.ovf",   overflow,   1'b0);
    check("full_pp.head",  out_nonce,  32'h62);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    check("full_pp.tail",  out_nonce,  32'hAB);
    step(0, 0, 0, 0, 0, 1);

    // Final round of the nonce space, then clear by job_start.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 31'h7FFF_FFFF, 0);
    check("exh.flag",   exhausted,   1'b1);
    check("exh.rounds", rounds_done, 32'd1);
    step(0, 1, 1, 1, 31'h7FFF_FFFF, 0);
    step(1, 0, 0, 0, 0, 0);
    check("exh.clear",  exhausted,   1'b0);
    check("exh.rclr",   rounds_done, 32'd0);
    check("exh.cclr",   fifo_count,  3'd0);

    // job_start coincident with a successful round.
    step(0, 1, 1, 0, 31'h44, 0);
    step(1, 1, 1, 1, 31'h99, 1);
    check("js_coinc.count",  fifo_count,  3'd0);
    check("js_coinc.rounds", rounds_done, 32'd0);

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 31'h70 + 31'(i), 0);
    for (int i = 0; i < 300; i++) step(0, 1, 1, 1, 31'(i), 0);
    check("sat.drops", drop_count, 8'd255);
    check("sat.head",  out_nonce,  32'hE0);

    // Asynchronous reset mid-stream with three entries held.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 31'h100 + 31'(i), 0);
    check("mid.count3", fifo_count, 3'd3);
    idle();
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_state("mid_rst");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 1, 0, 31'h0ABC, 0);
    check("post_rst.count", fifo_count, 3'd1);
    check("post_rst.nonce", out_nonce,  32'h1578);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
